// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch debouncer.
// The default window is 1 ms of the 125 MHz board clock.
package switch_debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd125000;

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit.
// Both flops reset synchronously to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : sync_2ff

// File: rtl/switch_debounce.sv
// Debounces a raw switch pin. The output follows the synchronised input
// only after the input has held a new level for DEBOUNCE_CYCLES cycles.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_switch,
  output logic o_switch
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sw_sync_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_r;
  logic             out_nxt_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_switch),
    .q   (sw_sync_s)
  );

  // Any return to the current output level throws away the partial count
  always_comb begin
    cnt_nxt_s = '0;
    out_nxt_s = out_r;
    if (sw_sync_s == out_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == TERMINAL) begin
      out_nxt_s = sw_sync_s;
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      out_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      out_r <= out_nxt_s;
    end
  end

  assign o_switch = out_r;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with an 8-cycle window: stimulus queues
// expected output edges (level, cycle), and a monitor pops them on each output change.
module tb_switch_debounce;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  logic i_switch;
  logic o_switch;

  always #4 clk = ~clk;

  switch_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_switch (i_switch),
    .o_switch (o_switch)
  );

  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   max_cnt = 0;
  bit   mon_en  = 1'b0;
  logic prev_o  = 1'b0;
  logic exp_val_q[$];
  int   exp_cyc_q[$];

  // Count rising edges so output changes can be timed
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_edge(input logic v, input int c);
    exp_val_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_seg(input logic v, input int len);
    i_switch = v;
    tick(len);
  endtask

  // Monitor: every output change must match the next queued expectation
  always @(negedge clk) begin : monitor
    logic ev;
    int   ec;
    if (cyc > 0 && int'(dut.cnt_r) > max_cnt) max_cnt = int'(dut.cnt_r);
    if (mon_en && o_switch !== prev_o) begin
      if (exp_val_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_edge: o_switch went to %b at cycle %0d, expected no change",
                 o_switch, cyc);
      end else begin
        ev = exp_val_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_bit("edge_level", o_switch, ev);
        check_int("edge_cycle", cyc, ec);
      end
      prev_o = o_switch;
    end
  end

  initial begin
    int c;
    rst      = 1'b1;
    i_switch = 1'b1;

    // Reset held 5 cycles with the input high
    repeat (5) begin
      @(negedge clk);
      check_bit("reset_hold", o_switch, 1'b0);
    end
    rst    = 1'b0;
    prev_o = 1'b0;
    mon_en = 1'b1;
    expect_edge(1'b1, cyc + N + 2);
    tick(N + 8);
    check_bit("post_reset_rise", o_switch, 1'b1);

    // Release bounce: every low burst is at most N-1 cycles
    drive_seg(1'b0, 3); drive_seg(1'b1, 2); drive_seg(1'b0, 1);
    drive_seg(1'b1, 5); drive_seg(1'b0, 7); drive_seg(1'b1, 3);
    check_bit("release_bounce_held", o_switch, 1'b1);
    i_switch = 1'b0;
    expect_edge(1'b0, cyc + N + 2);
    tick(N + 8);
    check_bit("release_settled", o_switch, 1'b0);

    // Press bounce
    drive_seg(1'b1, 3); drive_seg(1'b0, 2); drive_seg(1'b1, 1);
    drive_seg(1'b0, 5); drive_seg(1'b1, 7); drive_seg(1'b0, 3);
    check_bit("press_bounce_held", o_switch, 1'b0);
    i_switch = 1'b1;
    expect_edge(1'b1, cyc + N + 2);
    tick(N + 8);
    check_bit("press_settled", o_switch, 1'b1);

    // Boundary: a 7-cycle pulse is rejected, an 8-cycle pulse gets through
    drive_seg(1'b0, 7);
    drive_seg(1'b1, 12);
    check_bit("pulse7_rejected", o_switch, 1'b1);
    c = cyc;
    expect_edge(1'b0, c + N + 2);
    expect_edge(1'b1, c + 2 * N + 2);
    drive_seg(1'b0, 8);
    drive_seg(1'b1, N + 12);
    check_bit("pulse8_recovered", o_switch, 1'b1);

    // Reset lands on the 5th counting edge of a falling transition
    c = cyc;
    i_switch = 1'b0;
    tick(6);
    rst = 1'b1;
    expect_edge(1'b0, c + 7);
    tick(1);
    check_bit("midcount_reset_out", o_switch, 1'b0);
    check_int("midcount_reset_cnt", int'(dut.cnt_r), 0);
    tick(2);
    rst = 1'b0;
    tick(2 * N + 4);
    check_bit("post_midcount_low", o_switch, 1'b0);

    check_int("pending_edges", exp_val_q.size(), 0);
    check_int("max_counter", max_cnt, N - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule : tb_switch_debounce
